// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int adder_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One SEG-bit carry slice: registers slice sum, slice carry and valid.
module adder_seg_stage
    import adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv,
    input  logic           in_valid,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic           valid,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // SEG+1 bits so the slice carry is never truncated.
    logic [SEG:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (adv) begin
            valid <= in_valid;
            sum   <= total[SEG-1:0];
            cout  <= total[SEG];
        end
    end

endmodule

// File: rtl/adder_pipe_seg.sv
// Pipelined add/sub: one SEG-bit carry slice resolved per stage.
module adder_pipe_seg
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = adder_stages(WIDTH, SEG);

    if (SEG < 1 || WIDTH % SEG != 0 || STAGES < 1) begin : g_bad
        $fatal(1, "adder_pipe_seg: WIDTH must be a nonzero multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipe moves in lockstep, bubbles included.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        b_eff = b;
        c0    = cin;
        unique case (sub)
            ADD: begin
                b_eff = b;
                c0    = cin;
            end
            SUB: begin
                b_eff = ~b;
                c0    = 1'b1;
            end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g
        localparam int UP = WIDTH - (k + 1) * SEG;

        logic [SEG-1:0]       sa;
        logic [SEG-1:0]       sb;
        logic [SEG-1:0]       s;
        logic                 sc;
        logic                 vi;
        logic                 v;
        logic                 c;
        logic                 am;
        logic                 bm;
        logic [(k+1)*SEG-1:0] rs;

        if (k == 0) begin : g_src
            assign sa = a[SEG-1:0];
            assign sb = b_eff[SEG-1:0];
            assign sc = c0;
            assign vi = in_valid;
            assign rs = s;

            always_ff @(posedge clk) begin
                if (rst) begin
                    am <= 1'b0;
                    bm <= 1'b0;
                end else if (adv) begin
                    am <= a[WIDTH-1];
                    bm <= b_eff[WIDTH-1];
                end
            end
        end else begin : g_src
            logic [k*SEG-1:0] lo;

            assign sa = g[k-1].g_up.ua[SEG-1:0];
            assign sb = g[k-1].g_up.ub[SEG-1:0];
            assign sc = g[k-1].c;
            assign vi = g[k-1].v;
            assign rs = {s, lo};

            // Resolved low sums and operand sign bits ride with the beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    am <= 1'b0;
                    bm <= 1'b0;
                    lo <= '0;
                end else if (adv) begin
                    am <= g[k-1].am;
                    bm <= g[k-1].bm;
                    lo <= g[k-1].rs;
                end
            end
        end

        if (UP > 0) begin : g_up
            logic [UP-1:0] ua;
            logic [UP-1:0] ub;

            if (k == 0) begin : g_ld
                always_ff @(posedge clk) begin
                    if (adv) begin
                        ua <= a[WIDTH-1:SEG];
                        ub <= b_eff[WIDTH-1:SEG];
                    end
                end
            end else begin : g_ld
                always_ff @(posedge clk) begin
                    if (adv) begin
                        ua <= g[k-1].g_up.ua[SEG +: UP];
                        ub <= g[k-1].g_up.ub[SEG +: UP];
                    end
                end
            end
        end

        adder_seg_stage #(
            .SEG(SEG)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .in_valid (vi),
            .a        (sa),
            .b        (sb),
            .cin      (sc),
            .valid    (v),
            .sum      (s),
            .cout     (c)
        );
    end

    assign out_valid = g[STAGES-1].v;
    assign sum       = g[STAGES-1].rs;
    assign cout      = g[STAGES-1].c;
    assign ovf       = (g[STAGES-1].am == g[STAGES-1].bm)
                    && (sum[WIDTH-1] != g[STAGES-1].am);

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Scoreboard bench for adder_pipe_seg: random and directed beats vs. arithmetic model.
module tb_adder_pipe_seg;

    localparam int W   = 32;
    localparam int SEG = 8;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    adder_pipe_seg #(.WIDTH(W), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           t_acc;
        int           st_acc;
    } exp_t;

    exp_t         sbq[$];
    int           tests    = 0;
    int           fails    = 0;
    int           cyc      = 0;
    int           stalls   = 0;
    int           rdy_mode = 0;
    bit           armed    = 0;
    bit           post_rst = 0;
    bit           held     = 0;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;

    // Exact integer arithmetic; overflow = true result not representable.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t   e;
        longint ux = {32'd0, x};
        longint uy = {32'd0, y};
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint u;
        longint t;
        if (s) begin
            u      = ux - uy;
            t      = sx - sy;
            e.cout = (x >= y);
        end else begin
            u      = ux + uy + longint'(ci);
            t      = sx + sy + longint'(ci);
            e.cout = u[32];
        end
        e.sum    = u[31:0];
        e.ovf    = (t != longint'(signed'(e.sum)));
        e.t_acc  = 0;
        e.st_acc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            armed    = 1;
            post_rst = 1;
            held     = 0;
            sbq.delete();
        end else if (armed) begin
            if (post_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_sum", sum, 0);
                chk("rst_cout", cout, 0);
                chk("rst_ovf", ovf, 0);
                chk("rst_in_ready", in_ready, 1);
                post_rst = 0;
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_sum", sum, h_sum);
                chk("stall_cout", cout, h_cout);
                chk("stall_ovf", ovf, h_ovf);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: sum=%h with no beat outstanding (cycle %0d)",
                             sum, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                    chk("ovf", ovf, e.ovf);
                    chk("latency", cyc - e.t_acc, LAT + stalls - e.st_acc);
                end
            end
            if (in_valid && in_ready) begin
                e        = model(a, b, cin, sub);
                e.t_acc  = cyc;
                e.st_acc = stalls;
                sbq.push_back(e);
            end
            held = out_valid && !out_ready;
            if (held) begin
                h_sum  = sum;
                h_cout = cout;
                h_ovf  = ovf;
                stalls++;
            end
        end
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
        int n = 0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout: in_ready stuck at %0b", in_ready);
                $fatal(1, "send timeout");
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("drain_empty", sbq.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);

        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        drain();
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd5, 32'd7, 1'b1, 1'b1);
        drain();

        for (int i = 0; i < 10; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();

        fork
            for (int i = 0; i < 12; i++)
                send(pick(), pick(), 1'($urandom), 1'($urandom));
            begin
                repeat (6) @(negedge clk);
                rdy_mode = 1;
                repeat (3) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = $urandom;
        idle(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(8);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 2));
            send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        drain();
        rdy_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
